// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - operation encoding and EX-stage mul/div bus
//   oper_i       : decoded operation of the instruction in EX
//   reg1_i       : operand 1 (rs / dividend / MTHI-MTLO source)
//   reg2_i       : operand 2 (rt / divisor)
//   advance_i    : EX instruction moves to MEM this cycle
//   flush_i      : kill the EX instruction this cycle
//   stallreq_o   : hold IF/ID/EX while a divide is running
//   hilo_rdata_o : HI for MFHI, LO for MFLO, else 0
//   hi_o, lo_o   : architectural HI/LO
package ex_muldiv_pkg;
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } oper_t;
endpackage

interface ex_muldiv_if;
  ex_muldiv_pkg::oper_t oper_i;
  logic [31:0]          reg1_i;
  logic [31:0]          reg2_i;
  logic                 advance_i;
  logic                 flush_i;
  logic                 stallreq_o;
  logic [31:0]          hilo_rdata_o;
  logic [31:0]          hi_o;
  logic [31:0]          lo_o;

  // master: decode / pipeline control side
  modport master (
    output oper_i, reg1_i, reg2_i, advance_i, flush_i,
    input  stallreq_o, hilo_rdata_o, hi_o, lo_o
  );

  // slave: the multiply/divide unit
  modport slave (
    input  oper_i, reg1_i, reg2_i, advance_i, flush_i,
    output stallreq_o, hilo_rdata_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage multiply/divide unit owning HI/LO
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : ex_muldiv_if.slave (operation, operands, pipeline control,
//          stall request, HI/LO read data and architectural HI/LO)
//   DIV_BITS_PER_CYCLE : quotient bits per divide iteration (1 or 2)
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  localparam int NITER = 32 / DIV_BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic [31:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [31:0] dsr_q, dsr_d;     // divisor magnitude
  logic [31:0] dvd_q, dvd_d;     // raw dividend, needed for divide-by-zero HI
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_div;
  logic        is_sdiv;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rem_it, quo_it;
  logic [31:0] q_res, r_res;
  logic        stall;

  assign is_sdiv = (bus.oper_i == OP_DIV);
  assign is_div  = is_sdiv || (bus.oper_i == OP_DIVU);

  // Operands widened to 64 bits first so the low 64 product bits are exact.
  assign prod_s = $signed({{32{bus.reg1_i[31]}}, bus.reg1_i})
                * $signed({{32{bus.reg2_i[31]}}, bus.reg2_i});
  assign prod_u = {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};

  // Restoring division step(s). The 33-bit trial never overflows because
  // the partial remainder is always below the divisor.
  always_comb begin
    rem_it = rem_q;
    quo_it = quo_q;
    for (int k = 0; k < DIV_BITS_PER_CYCLE; k++) begin
      logic [32:0] trial;
      trial = {rem_it, quo_it[31]};
      if (trial >= {1'b0, dsr_q}) begin
        rem_it = trial[31:0] - dsr_q;
        quo_it = {quo_it[30:0], 1'b1};
      end else begin
        rem_it = trial[31:0];
        quo_it = {quo_it[30:0], 1'b0};
      end
    end
  end

  // Sign correction is applied on the way out so DONE simply holds state.
  // Divide by zero bypasses it: magnitude arithmetic would give the wrong LO.
  assign q_res = dz_q ? 32'hFFFF_FFFF : (qneg_q ? (~quo_q + 32'd1) : quo_q);
  assign r_res = dz_q ? dvd_q         : (rneg_q ? (~rem_q + 32'd1) : rem_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else if (is_div) begin
          stall   = 1'b1;
          state_d = S_BUSY;
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          quo_d   = (is_sdiv && bus.reg1_i[31]) ? (~bus.reg1_i + 32'd1) : bus.reg1_i;
          dsr_d   = (is_sdiv && bus.reg2_i[31]) ? (~bus.reg2_i + 32'd1) : bus.reg2_i;
          dvd_d   = bus.reg1_i;
          qneg_d  = is_sdiv && (bus.reg1_i[31] ^ bus.reg2_i[31]);
          rneg_d  = is_sdiv && bus.reg1_i[31];
          dz_d    = (bus.reg2_i == 32'd0);
        end else if (bus.advance_i) begin
          unique case (bus.oper_i)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MTHI:  hi_d = bus.reg1_i;
            OP_MTLO:  lo_d = bus.reg1_i;
            default:  ;
          endcase
        end
      end

      S_BUSY: begin
        if (bus.flush_i || !is_div) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          rem_d = rem_it;
          quo_d = quo_it;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(NITER - 1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (bus.flush_i || !is_div) begin
          state_d = S_IDLE;
        end else if (bus.advance_i) begin
          lo_d    = q_res;
          hi_d    = r_res;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dsr_q   <= 32'd0;
      dvd_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.stallreq_o   = stall;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;
  assign bus.hilo_rdata_o = (bus.oper_i == OP_MFHI) ? hi_q :
                            (bus.oper_i == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - randomized self-checking bench for ex_muldiv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int DBPC       = 1;
  localparam int STALL_CYCS = 32 / DBPC + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] m_hi, m_lo;

  ex_muldiv_if bus();

  ex_muldiv #(.DIV_BITS_PER_CYCLE(DBPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Architectural result of one committed instruction, straight from the ISA rules.
  task automatic model(input oper_t op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      OP_MULTU: begin up = longint'(a) * longint'(b); m_hi = up[63:32]; m_lo = up[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == OP_DIV) begin
          sp = sa / sb; m_lo = sp[31:0];
          sp = sa % sb; m_hi = sp[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    bus.oper_i    = OP_NOP;
    bus.reg1_i    = 32'd0;
    bus.reg2_i    = 32'd0;
    bus.advance_i = 1'b1;
    bus.flush_i   = 1'b0;
  endtask

  task automatic check_hilo(input string tag);
    chk({tag, ".hi"}, bus.hi_o, m_hi);
    chk({tag, ".lo"}, bus.lo_o, m_lo);
  endtask

  // Single-cycle op: issued with advance high, committed on the next edge.
  task automatic do_op(input oper_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.oper_i = op; bus.reg1_i = a; bus.reg2_i = b; bus.advance_i = 1'b1;
    #1 chk("op.stall", {31'd0, bus.stallreq_o}, 32'd0);
    @(negedge clk);
    idle_inputs();
    model(op, a, b);
    #1 chk("op.stall_after", {31'd0, bus.stallreq_o}, 32'd0);
    check_hilo("op");
  endtask

  // Divide: advance held low while stalled, then 'hold' extra DONE cycles.
  task automatic do_div(input oper_t op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int cyc;
    @(negedge clk);
    bus.oper_i = op; bus.reg1_i = a; bus.reg2_i = b; bus.advance_i = 1'b0;
    #1;
    cyc = 0;
    while (bus.stallreq_o === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("div.stall_cycles", cyc, STALL_CYCS);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1 chk("div.hold_stall", {31'd0, bus.stallreq_o}, 32'd0);
      check_hilo("div.hold");
    end
    @(negedge clk);
    bus.advance_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    model(op, a, b);
    #1 check_hilo("div");
  endtask

  task automatic check_mf();
    @(negedge clk);
    bus.oper_i = OP_MFHI;
    #1 chk("mfhi", bus.hilo_rdata_o, m_hi);
    bus.oper_i = OP_MFLO;
    #1 chk("mflo", bus.hilo_rdata_o, m_lo);
    bus.oper_i = OP_NOP;
    #1 chk("rdata_nop", bus.hilo_rdata_o, 32'd0);
  endtask

  initial begin
    oper_t       op;
    logic [31:0] a, b;
    int          cyc;

    idle_inputs();
    rst = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_hilo("reset");
    chk("reset.stall", {31'd0, bus.stallreq_o}, 32'd0);
    chk("reset.rdata", bus.hilo_rdata_o, 32'd0);

    do_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    do_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    do_div(OP_DIVU, 32'd100, 32'd7, 5);
    do_div(OP_DIVU, 32'h0000_1234, 32'd0, 1);
    do_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(OP_DIV,  32'hFFFF_FF00, 32'd0, 0);

    // Flush during BUSY iteration 10.
    @(negedge clk);
    bus.oper_i = OP_DIV; bus.reg1_i = 32'd1000; bus.reg2_i = 32'd3; bus.advance_i = 1'b0;
    repeat (11) @(negedge clk);
    bus.flush_i = 1'b1;
    #1 chk("flush.stall", {31'd0, bus.stallreq_o}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1 chk("flush.stall_after", {31'd0, bus.stallreq_o}, 32'd0);
    check_hilo("flush");
    repeat (3) @(negedge clk);
    #1 check_hilo("flush.later");

    do_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    check_mf();

    // Divide followed immediately by a protocol abort while BUSY.
    @(negedge clk);
    bus.oper_i = OP_DIVU; bus.reg1_i = 32'd50; bus.reg2_i = 32'd5; bus.advance_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.oper_i = OP_NOP;
    #1 chk("abort.stall", {31'd0, bus.stallreq_o}, 32'd0);
    repeat (2) @(negedge clk);
    #1 check_hilo("abort");

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        3: op = OP_DIVU;
        4: op = OP_MTHI;
        default: op = OP_MTLO;
      endcase
      a = $urandom();
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom();
      endcase
      if (op == OP_DIV || op == OP_DIVU) do_div(op, a, b, $urandom_range(0, 3));
      else do_op(op, a, b);
      check_mf();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
